// File: rtl/core_pkg.sv
// core_pkg: shared types for the RISC-X execute stage.
//   alu_op_t       - ALU operation, including the M-extension ops
//   reg_bank_mux_t - destination register bank
//   data_type_t    - memory access size
//   div_state_t    - serial divider FSM state
//   ex_reg_t       - ID->EX pipeline register contents
package core_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic {
    X_REG = 1'b0,
    F_REG = 1'b1
  } reg_bank_mux_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } data_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_ITER = 32;

  typedef struct packed {
    alu_op_t       alu_op;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [4:0]    rd_addr;
    reg_bank_mux_t rd_dst_bank;
    logic          mem_req;
    logic          mem_wen;
    logic          mem_sign_extend;
    data_type_t    mem_data_type;
    logic [31:0]   mem_wdata;
    logic          reg_alu_wen;
    logic          reg_mem_wen;
    logic          valid;
  } ex_reg_t;

  localparam ex_reg_t EX_REG_RESET = '{
    alu_op:          ALU_ADD,
    alu_a:           32'd0,
    alu_b:           32'd0,
    rd_addr:         5'd0,
    rd_dst_bank:     X_REG,
    mem_req:         1'b0,
    mem_wen:         1'b0,
    mem_sign_extend: 1'b0,
    mem_data_type:   WORD,
    mem_wdata:       32'd0,
    reg_alu_wen:     1'b0,
    reg_mem_wen:     1'b0,
    valid:           1'b0
  };

  function automatic logic is_div_op(alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: 32-step restoring divider with single-cycle special cases.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   start_i          - a valid divide op is present in EX
//   signed_i         - DIV/REM (1) vs DIVU/REMU (0)
//   dividend_i       - dividend, divisor_i - divisor
//   abort_i          - drop any division in progress (pipeline flush)
//   ack_i            - result consumed; leave DONE
//   busy_o           - division in flight (start cycle and RUN)
//   done_o           - quotient_o/remainder_o are valid this cycle
//
// state | meaning
// IDLE  | waiting; special cases (x/0, MIN/-1) answered combinationally here
// RUN   | one shift-subtract step per cycle, 32 steps
// DONE  | sign-corrected result held until ack_i
module serial_divider
  import core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        abort_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic        div_zero, div_ovf, special;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_step, quot_step;

  always_comb begin
    div_zero = (divisor_i == 32'd0);
    div_ovf  = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    a_neg    = signed_i & dividend_i[31];
    b_neg    = signed_i & divisor_i[31];
    a_mag    = a_neg ? (32'd0 - dividend_i) : dividend_i;
    b_mag    = b_neg ? (32'd0 - divisor_i) : divisor_i;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while quotient bits enter at the LSB.
    rem_sh    = {rem_q, quot_q[31]};
    fits      = (rem_sh >= {1'b0, dsr_q});
    rem_step  = fits ? 32'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
    quot_step = {quot_q[30:0], fits};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    case (state_q)
      IDLE: begin
        if (start_i && !special && !abort_i) begin
          quot_d  = a_mag;
          rem_d   = 32'd0;
          dsr_d   = b_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          cnt_d   = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          quot_d = quot_step;
          rem_d  = rem_step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITER - 1)) begin
            quot_d  = q_neg_q ? (32'd0 - quot_step) : quot_step;
            rem_d   = r_neg_q ? (32'd0 - rem_step) : rem_step;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort_i || ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dsr_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  always_comb begin
    busy_o      = ((state_q == IDLE) && start_i && !special && !abort_i) || (state_q == RUN);
    done_o      = ((state_q == IDLE) && start_i && special && !abort_i) || (state_q == DONE);
    quotient_o  = quot_q;
    remainder_o = rem_q;
    if (state_q == IDLE) begin
      quotient_o  = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      remainder_o = div_zero ? dividend_i : 32'd0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RISC-X execute stage.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   *_id_i                  - instruction fields from ID, captured when !stall_ex_i
//   *_ex_o                  - registered fields / ALU result towards MEM
//   busy_ex_o               - divider occupies EX
//   stall_ex_i, flush_ex_i  - pipeline control
module ex_stage
  import core_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  alu_op_t       alu_op_id_i,
  input  logic [31:0]   alu_a_id_i,
  input  logic [31:0]   alu_b_id_i,
  input  logic [4:0]    rd_addr_id_i,
  input  reg_bank_mux_t rd_dst_bank_id_i,
  input  logic          mem_req_id_i,
  input  logic          mem_wen_id_i,
  input  logic          mem_sign_extend_id_i,
  input  data_type_t    mem_data_type_id_i,
  input  logic [31:0]   mem_wdata_id_i,
  input  logic          reg_alu_wen_id_i,
  input  logic          reg_mem_wen_id_i,
  input  logic          valid_id_i,
  output logic [4:0]    rd_addr_ex_o,
  output reg_bank_mux_t rd_dst_bank_ex_o,
  output logic [31:0]   alu_result_ex_o,
  output logic          mem_req_ex_o,
  output logic          mem_wen_ex_o,
  output data_type_t    mem_data_type_ex_o,
  output logic          mem_sign_extend_ex_o,
  output logic [31:0]   mem_wdata_ex_o,
  output logic          reg_alu_wen_ex_o,
  output logic          reg_mem_wen_ex_o,
  output logic          valid_ex_o,
  output logic          busy_ex_o,
  input  logic          stall_ex_i,
  input  logic          flush_ex_i
);

  ex_reg_t ex_q, ex_d;

  // A flush only kills the control bits; data fields are left as they were.
  always_comb begin
    ex_d = ex_q;
    if (!stall_ex_i) begin
      if (flush_ex_i) begin
        ex_d.valid       = 1'b0;
        ex_d.mem_req     = 1'b0;
        ex_d.mem_wen     = 1'b0;
        ex_d.reg_alu_wen = 1'b0;
        ex_d.reg_mem_wen = 1'b0;
      end else begin
        ex_d.alu_op          = alu_op_id_i;
        ex_d.alu_a           = alu_a_id_i;
        ex_d.alu_b           = alu_b_id_i;
        ex_d.rd_addr         = rd_addr_id_i;
        ex_d.rd_dst_bank     = rd_dst_bank_id_i;
        ex_d.mem_req         = mem_req_id_i;
        ex_d.mem_wen         = mem_wen_id_i;
        ex_d.mem_sign_extend = mem_sign_extend_id_i;
        ex_d.mem_data_type   = mem_data_type_id_i;
        ex_d.mem_wdata       = mem_wdata_id_i;
        ex_d.reg_alu_wen     = reg_alu_wen_id_i;
        ex_d.reg_mem_wen     = reg_mem_wen_id_i;
        ex_d.valid           = valid_id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ex_q <= EX_REG_RESET;
    else       ex_q <= ex_d;
  end

  logic        div_start, div_signed, div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  assign div_start  = ex_q.valid && is_div_op(ex_q.alu_op);
  assign div_signed = (ex_q.alu_op == ALU_DIV) || (ex_q.alu_op == ALU_REM);

  serial_divider u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start),
    .signed_i    (div_signed),
    .dividend_i  (ex_q.alu_a),
    .divisor_i   (ex_q.alu_b),
    .abort_i     (flush_ex_i),
    .ack_i       (!stall_ex_i),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  logic [31:0]        a, b;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [31:0]        alu_res;

  always_comb begin
    a = ex_q.alu_a;
    b = ex_q.alu_b;
    // 33-bit operands cover signed and unsigned variants in one signed multiply.
    mul_a = {((ex_q.alu_op == ALU_MULH) || (ex_q.alu_op == ALU_MULHSU)) & a[31], a};
    mul_b = {(ex_q.alu_op == ALU_MULH) & b[31], b};
    prod  = 64'(mul_a) * 64'(mul_b);

    alu_res = 32'd0;
    case (ex_q.alu_op)
      ALU_ADD:    alu_res = a + b;
      ALU_SUB:    alu_res = a - b;
      ALU_AND:    alu_res = a & b;
      ALU_OR:     alu_res = a | b;
      ALU_XOR:    alu_res = a ^ b;
      ALU_SLL:    alu_res = a << b[4:0];
      ALU_SRL:    alu_res = a >> b[4:0];
      ALU_SRA:    alu_res = $signed(a) >>> b[4:0];
      ALU_SLT:    alu_res = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   alu_res = {31'd0, a < b};
      ALU_MUL:    alu_res = prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = prod[63:32];
      ALU_DIV,
      ALU_DIVU:   alu_res = div_done ? div_quot : 32'd0;
      ALU_REM,
      ALU_REMU:   alu_res = div_done ? div_rem : 32'd0;
      default:    alu_res = 32'd0;
    endcase
  end

  assign busy_ex_o            = div_busy;
  assign alu_result_ex_o      = alu_res;
  assign rd_addr_ex_o         = ex_q.rd_addr;
  assign rd_dst_bank_ex_o     = ex_q.rd_dst_bank;
  assign mem_wen_ex_o         = ex_q.mem_wen;
  assign mem_data_type_ex_o   = ex_q.mem_data_type;
  assign mem_sign_extend_ex_o = ex_q.mem_sign_extend;
  assign mem_wdata_ex_o       = ex_q.mem_wdata;
  assign reg_mem_wen_ex_o     = ex_q.reg_mem_wen;
  assign valid_ex_o           = ex_q.valid & ~div_busy;
  assign reg_alu_wen_ex_o     = ex_q.reg_alu_wen & ~div_busy;
  assign mem_req_ex_o         = ex_q.mem_req & ~div_busy;

endmodule
